soc_system_button_pio: RTL and testbench

Avalon-MM slave input PIO for the push-button bank, the input-direction counterpart of the LED output PIO on the same lightweight HPS-to-FPGA bridge. It synchronises and debounces `in_port`, exposes the debounced level, latches selected edges in a bit-clearable edge-capture register, and raises a maskable level interrupt to the HPS GIC.

---
 rtl/soc_system_pio_pkg.sv | 13 +
 rtl/soc_system_button_debounce.sv | 52 +++++
 rtl/soc_system_button_pio.sv | 84 ++++++++
 tb/tb_soc_system_button_pio.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register-map and edge-type constants for the lightweight-bridge PIO blocks.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_button_debounce.sv
// One button bit: two-flop synchroniser, stable-count debouncer, and a one-cycle
// event pulse on the cycle the debounced state flips (new value is ~state).
module soc_system_button_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic state,
  output logic event_vld
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with state restarts the count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    event_vld = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = sync2_q;
        event_vld = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_BIT;
      sync2_q <= IDLE_BIT;
      state_q <= IDLE_BIT;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_bit;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/soc_system_button_pio.sv
// Avalon-MM input PIO for the push-button bank: debounced DATA, IRQMASK,
// write-1-to-clear EDGECAPTURE and a level irq; zero-latency combinational reads.
module soc_system_button_pio
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] state, ev, edge_set, clr;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_BIT        (IDLE_LEVEL[i])
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (in_port[i]),
      .state     (state[i]),
      .event_vld (ev[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // At an event the new level is the complement of the current state.
  always_comb begin
    if (EDGE_TYPE == EDGE_RISE)      edge_set = ev & ~state;
    else if (EDGE_TYPE == EDGE_FALL) edge_set = ev & state;
    else                             edge_set = ev;
  end

  always_comb begin
    wr_en     = chipselect && !write_n;
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
    // Set wins over a coincident clear so no edge is lost.
    edgecap_d = (edgecap_q & ~clr) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = state;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_button_pio.sv
// Bench for soc_system_button_pio: falling-edge and any-edge instances on a shared
// bus, a window-based debounce model checked every cycle, plus literal expectations.
module tb_soc_system_button_pio;
  localparam int W  = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset, cs, write_n;
  logic [1:0]    address;
  logic [31:0]   writedata, rd1, rd2;
  logic [W-1:0]  in_port;
  logic          irq1, irq2;
  int            total = 0, bad = 0;
  bit            chk_en = 1'b0;

  always #5 clk = ~clk;

  soc_system_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));

  soc_system_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  // Model: a bit flips once the last DC synchronised samples all disagree with it.
  logic [W-1:0] m_s1, m_state, m_mask, m_ec1, m_ec2, m_chg, m_new, m_clr;
  logic [W-1:0] m_hist [DC];

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '1; m_state = '1; m_mask = '0; m_ec1 = '0; m_ec2 = '0;
      for (int i = 0; i < DC; i++) m_hist[i] = '1;
    end else begin
      m_chg = '1;
      for (int i = 0; i < DC; i++) m_chg &= m_hist[i] ^ m_state;
      m_new = m_state ^ m_chg;
      m_clr = (cs && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_ec1 = (m_ec1 & ~m_clr) | (m_chg & ~m_new);
      m_ec2 = (m_ec2 & ~m_clr) | m_chg;
      if (cs && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_state = m_new;
      for (int i = 0; i < DC - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[DC-1] = m_s1;
      m_s1 = in_port;
    end
  end

  function automatic logic [31:0] model_rd(logic [1:0] a, logic [W-1:0] ec);
    case (a)
      2'd0:    return {28'd0, m_state};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, ec};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_fall", rd1, model_rd(address, m_ec1));
      check("rd_any",  rd2, model_rd(address, m_ec2));
      check("irq_fall", {31'd0, irq1}, {31'd0, |(m_ec1 & m_mask)});
      check("irq_any",  {31'd0, irq2}, {31'd0, |(m_ec2 & m_mask)});
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    cs = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick(1);
    cs = 1'b0; write_n = 1'b1;
  endtask

  task automatic peek(string nm, bit any, logic [1:0] a, logic [31:0] e);
    address = a;
    #1;
    check(nm, any ? rd2 : rd1, e);
  endtask

  initial begin
    reset = 1'b1; in_port = 4'hF; cs = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    peek("rst_data", 0, 2'd0, 32'hF);
    peek("rst_mask", 0, 2'd2, 32'h0);
    peek("rst_ec",   0, 2'd3, 32'h0);
    peek("rst_dir",  0, 2'd1, 32'h0);
    check("rst_irq", {31'd0, irq1}, 32'd0);
    for (int i = 0; i < 6; i++) begin in_port = 4'($urandom); tick(1); end
    in_port = 4'hF; tick(1);
    reset = 1'b0; tick(10);
    peek("rst_toggle_ec", 1, 2'd3, 32'h0);

    // Falling edge on bit 0: visible exactly DC+1 edges after sampling.
    in_port = 4'hE; tick(5);
    peek("fall_pre_data", 0, 2'd0, 32'hF);
    tick(1);
    peek("fall_data", 0, 2'd0, 32'hE);
    peek("fall_ec",   0, 2'd3, 32'h1);
    check("fall_irq_masked", {31'd0, irq1}, 32'd0);
    wr(2'd2, 32'h1);
    check("mask_irq", {31'd0, irq1}, 32'd1);
    wr(2'd3, 32'h1);
    peek("clr_ec", 0, 2'd3, 32'h0);

    // Bounce on bit 1 never survives DC samples.
    for (int r = 0; r < 10; r++) begin
      in_port = 4'hC; tick(3);
      in_port = 4'hE; tick(1);
    end
    tick(10);
    peek("bounce_data", 0, 2'd0, 32'hE);
    peek("bounce_ec",   1, 2'd3, 32'h0);

    // Rising edge: data follows, falling-only instance does not capture.
    in_port = 4'hF; tick(8);
    peek("rise_data",   0, 2'd0, 32'hF);
    peek("rise_ec",     0, 2'd3, 32'h0);
    peek("rise_ec_any", 1, 2'd3, 32'h1);
    wr(2'd3, 32'hF);

    in_port = 4'hC; tick(8);
    peek("two_ec", 0, 2'd3, 32'h3);
    wr(2'd3, 32'h2);
    peek("part_clr", 0, 2'd3, 32'h1);
    check("part_irq", {31'd0, irq1}, 32'd1);
    wr(2'd3, 32'h1);
    peek("full_clr", 0, 2'd3, 32'h0);
    check("full_irq", {31'd0, irq1}, 32'd0);

    // Clear-write lands on the same edge as bit 2's event.
    in_port = 4'h8; tick(5);
    wr(2'd3, 32'h4);
    peek("coincide_ec", 0, 2'd3, 32'h4);

    // Reset while the rising count is at 2.
    in_port = 4'hF; tick(4);
    peek("mid_data", 0, 2'd0, 32'h8);
    reset = 1'b1; tick(1); reset = 1'b0;
    peek("mid_rst_data", 0, 2'd0, 32'hF);
    peek("mid_rst_ec",   1, 2'd3, 32'h0);
    tick(8);
    peek("mid_after_ec", 1, 2'd3, 32'h0);

    for (int c = 0; c < 4000; c++) begin
      int p;
      p = ((c / 250) % 2 == 0) ? 3 : 19;
      for (int b = 0; b < W; b++) if ($urandom_range(p) == 0) in_port[b] = ~in_port[b];
      reset     = ($urandom_range(299) == 0);
      address   = 2'($urandom_range(3));
      cs        = ($urandom_range(3) == 0);
      write_n   = ($urandom_range(1) == 0);
      writedata = $urandom;
      tick(1);
    end
    cs = 1'b0; write_n = 1'b1; reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
